pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output dead-time inserter placed directly downstream of the 4-bit up/down PWM generator. It takes the single-ended PWM waveform and drives a high-side/low-side gate pair so that the two outputs are never high at the same time. A programmable gap of both-off cycles is inserted at every switch-over. Pulses shorter than the dead time are swallowed and flagged.

## Interface
- Parameters
  - `DT_W`, default 4: width of the dead-time setting and the internal timer.
- Ports
  - Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk` in, 1: the single clock; all state updates on its rising edge.
  - `rst` in, 1: synchronous, active-high reset.
  - `en` in, 1: output enable; 0 forces both outputs off.
  - `PWM_in` in, 1: PWM waveform from the upstream generator, same clock domain.
  - `dead_cnt` in, DT_W: dead time in `clk` cycles; sampled only when a dead interval starts.
  - `hi_out` out, 1: high-side drive.
  - `lo_out` out, 1: low-side drive.
  - `dead_active` out, 1: 1 while in a dead interval.
  - `swallow` out, 1: one-cycle pulse when a dead interval ends on the same side it started from.

## Operation
- FSM states:
  - OFF: both outputs 0.
  - LO_ON: `lo_out`=1.
  - HI_ON: `hi_out`=1.
  - DEAD: both outputs 0, `dead_active`=1.
- Outputs are a Moore decode of the state register. All outputs are registered-equivalent.
- Reset forces state OFF, timer 0, `prev_side` 0, and all outputs 0. This overrides every other input, including mid-dead-interval.
- `en`=0 in any state: next state is OFF. This has priority over all transitions below.
- Transitions:
  - OFF with `en`=1: go to DEAD, load the timer, set `prev_side` = !`PWM_in`. This guarantees a gap after enable and no swallow report on the first exit.
  - LO_ON with `PWM_in`=1: go to DEAD, load the timer, set `prev_side`=LO.
  - HI_ON with `PWM_in`=0: go to DEAD, load the timer, set `prev_side`=HI.
  - DEAD with timer != 0: decrement the timer.
  - DEAD with timer == 0: go to HI_ON if `PWM_in`=1, else LO_ON.
- `swallow`=1 for the exit cycle only, when the destination side equals `prev_side`.
- Timer load rules:
  - Load value is `dead_cnt`-1.
  - `dead_cnt`=0 is treated as 1; the minimum gap is always 1 cycle.
  - Unsigned arithmetic, DT_W bits, no wrap: the load never underflows because of the 0→1 clamp.
- `dead_cnt` changes during a dead interval have no effect until the next load.

## Timing
- Define D = max(`dead_cnt`,1).
- Switch-over: `PWM_in` changes and is sampled at edge n while in an ON state.
  - The active output falls after edge n.
  - Both outputs stay 0 for exactly D cycles.
  - The new output rises after edge n+D.
- Edge-to-opposite-output latency is therefore D+1 clocks. The turning-off latency is 1 clock.
- `hi_out`&`lo_out`=1 is unreachable in all states, including reset release and `en` toggles.
- A `PWM_in` pulse shorter than D cycles is not reproduced. The output returns to the prior side, `swallow` pulses, and no extra switching occurs.
- `PWM_in` toggling several times within DEAD: only its value at the expiry edge matters.
- `en` falling: both outputs 0 one cycle later. `en` rising: outputs stay 0 for D+1 cycles.
- At 100% duty input (`PWM_in` constant 1) `hi_out` holds 1 indefinitely. At 0% duty `lo_out` holds 1.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum `dt_state_t` (OFF, LO_ON, HI_ON, DEAD);
  - the side constants LO=0, HI=1;
  - the default `DT_W`.
- One sub-module, `dt_timer`: a DT_W-bit loadable down-counter with `load`, `load_val`, `dec` inputs and a `zero` output.
- The FSM, the `prev_side` register and the output decode live in `pwm_deadtime`.

## Test plan
- Reset/enable:
  - Stimulus: `rst`=1 for 3 cycles, `en`=1, `PWM_in`=0, `dead_cnt`=3.
  - Required: outputs 0 during reset. After release, both outputs 0 for 4 cycles, then `lo_out`=1, with no `swallow`.
- Normal switch-over:
  - Stimulus: `dead_cnt`=3, `PWM_in` goes 0→1 at edge n.
  - Required: `lo_out`=0 from n+1, `dead_active`=1 for cycles n+1..n+3, `hi_out`=1 from n+4.
  - Repeat for 1→0 with the mirrored response.
- Zero dead time:
  - Stimulus: `dead_cnt`=0, `PWM_in` toggles.
  - Required: exactly one both-off cycle per switch-over.
- Swallowed pulse:
  - Stimulus: `dead_cnt`=5, `PWM_in` 1-cycle high pulse while in LO_ON.
  - Required: 5 dead cycles, return to `lo_out`=1, `swallow`=1 for exactly 1 cycle, `hi_out` never 1.
- `en` mid-operation:
  - Stimulus: drop `en` during DEAD and during HI_ON; also assert `rst` mid-DEAD.
  - Required: OFF on the next cycle. Re-enable yields a full D-cycle gap.
- Randomized cross-check:
  - Stimulus: drive from the upstream PWM block with random 4-bit duty and random `dead_cnt` over 10k cycles.
  - Required: the assertion `!(hi_out&&lo_out)` never fires, and every gap is at least max(`dead_cnt`,1).

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM dead-time inserter.
package pwm_pkg;

  localparam int unsigned DT_W_DEFAULT = 4;

  // Side identifiers used for prev_side and exit-direction comparisons
  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    LO_ON = 2'd1,
    HI_ON = 2'd2,
    DEAD  = 2'd3
  } dt_state_t;

endpackage

// File: rtl/dt_timer.sv
// Loadable down-counter that times the dead interval; load wins over dec.
module dt_timer
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [DT_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [DT_W-1:0] cnt_q;
  logic [DT_W-1:0] cnt_d;

  // Next count: load, else decrement (saturating at zero), else hold
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time and
// short-pulse swallowing; outputs are decoded from registered state.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            PWM_in,
  input  logic [DT_W-1:0] dead_cnt,
  output logic            hi_out,
  output logic            lo_out,
  output logic            dead_active,
  output logic            swallow
);

  dt_state_t       state_q;
  dt_state_t       state_d;
  logic            prev_side_q;
  logic            prev_side_d;
  logic            swallow_q;
  logic            swallow_d;
  logic            load_c;
  logic            dec_c;
  logic            zero_c;
  logic [DT_W-1:0] load_val_c;

  // Timer reload value: max(dead_cnt,1)-1, never underflows
  always_comb begin
    load_val_c = '0;
    if (dead_cnt != '0) begin
      load_val_c = dead_cnt - DT_W'(1);
    end
  end

  dt_timer #(
    .DT_W(DT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .load_val(load_val_c),
    .dec     (dec_c),
    .zero    (zero_c)
  );

  // Next-state logic; en low overrides every transition
  always_comb begin
    state_d     = state_q;
    prev_side_d = prev_side_q;
    swallow_d   = 1'b0;
    load_c      = 1'b0;
    dec_c       = 1'b0;
    if (!en) begin
      state_d = OFF;
    end else begin
      case (state_q)
        OFF: begin
          // Opposite of current input so the first exit never reports a swallow
          state_d     = DEAD;
          load_c      = 1'b1;
          prev_side_d = ~PWM_in;
        end
        LO_ON: begin
          if (PWM_in) begin
            state_d     = DEAD;
            load_c      = 1'b1;
            prev_side_d = LO;
          end
        end
        HI_ON: begin
          if (!PWM_in) begin
            state_d     = DEAD;
            load_c      = 1'b1;
            prev_side_d = HI;
          end
        end
        DEAD: begin
          if (!zero_c) begin
            dec_c = 1'b1;
          end else begin
            state_d   = PWM_in ? HI_ON : LO_ON;
            swallow_d = (PWM_in == prev_side_q);
          end
        end
        default: state_d = OFF;
      endcase
    end
  end

  // State, side memory and swallow pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OFF;
      prev_side_q <= LO;
      swallow_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_side_q <= prev_side_d;
      swallow_q   <= swallow_d;
    end
  end

  assign hi_out      = (state_q == HI_ON);
  assign lo_out      = (state_q == LO_ON);
  assign dead_active = (state_q == DEAD);
  assign swallow     = swallow_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed vector table plus a randomized upstream-PWM run for pwm_deadtime.
module tb_pwm_deadtime;

  localparam int unsigned DT_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dead_cnt;
  logic            hi_out;
  logic            lo_out;
  logic            dead_active;
  logic            swallow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       pwm;
    logic [3:0] dc;
    logic       hi;
    logic       lo;
    logic       dead;
    logic       sw;
  } vec_t;

  vec_t vecs[$];

  pwm_deadtime #(.DT_W(DT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .PWM_in     (pwm_in),
    .dead_cnt   (dead_cnt),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .dead_active(dead_active),
    .swallow    (swallow)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic e, input logic p, input int d,
                              input logic h, input logic l, input logic da, input logic s);
    vec_t v;
    v.rst = r; v.en = e; v.pwm = p; v.dc = 4'(d);
    v.hi = h; v.lo = l; v.dead = da; v.sw = s;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
    end
  endtask

  initial begin
    int cnt;
    logic up;
    int duty;
    int run;
    int dmin;

    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; dead_cnt = '0;

    //    rst en pwm dc   hi lo dead sw
    // reset then enable, D=3: 1 OFF cycle + 3 dead cycles, then lo
    add(1, 1, 0, 3,   0, 0, 0, 0);
    add(1, 1, 0, 3,   0, 0, 0, 0);
    add(1, 1, 0, 3,   0, 0, 0, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 1, 0, 0);
    add(0, 1, 0, 3,   0, 1, 0, 0);
    // 0->1 switch-over, D=3
    add(0, 1, 1, 3,   0, 0, 1, 0);
    add(0, 1, 1, 3,   0, 0, 1, 0);
    add(0, 1, 1, 3,   0, 0, 1, 0);
    add(0, 1, 1, 3,   1, 0, 0, 0);
    add(0, 1, 1, 3,   1, 0, 0, 0);
    // 1->0 switch-over, D=3
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 1, 0, 0);
    add(0, 1, 0, 3,   0, 1, 0, 0);
    // dead_cnt=0 behaves as one dead cycle
    add(0, 1, 1, 0,   0, 0, 1, 0);
    add(0, 1, 1, 0,   1, 0, 0, 0);
    add(0, 1, 0, 0,   0, 0, 1, 0);
    add(0, 1, 0, 0,   0, 1, 0, 0);
    add(0, 1, 0, 0,   0, 1, 0, 0);
    // 1-cycle high pulse with D=5 is swallowed
    add(0, 1, 1, 5,   0, 0, 1, 0);
    add(0, 1, 0, 5,   0, 0, 1, 0);
    add(0, 1, 0, 5,   0, 0, 1, 0);
    add(0, 1, 0, 5,   0, 0, 1, 0);
    add(0, 1, 0, 5,   0, 0, 1, 0);
    add(0, 1, 0, 5,   0, 1, 0, 1);
    add(0, 1, 0, 5,   0, 1, 0, 0);
    // toggling inside DEAD: only the expiry-edge value counts
    add(0, 1, 1, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 1, 3,   0, 0, 1, 0);
    add(0, 1, 1, 3,   1, 0, 0, 0);
    // en drop in HI_ON, re-enable with D=2 gives D+1 off cycles
    add(0, 0, 1, 2,   0, 0, 0, 0);
    add(0, 1, 1, 2,   0, 0, 1, 0);
    add(0, 1, 1, 2,   0, 0, 1, 0);
    add(0, 1, 1, 2,   1, 0, 0, 0);
    // en drop in DEAD, re-enable gives a full gap
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 0, 0, 3,   0, 0, 0, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 0, 1, 0);
    add(0, 1, 0, 3,   0, 1, 0, 0);
    // dead_cnt change inside DEAD is ignored until next load
    add(0, 1, 1, 2,   0, 0, 1, 0);
    add(0, 1, 1, 7,   0, 0, 1, 0);
    add(0, 1, 1, 7,   1, 0, 0, 0);
    add(0, 1, 1, 7,   1, 0, 0, 0);
    // 1-cycle low pulse from HI side is swallowed
    add(0, 1, 0, 2,   0, 0, 1, 0);
    add(0, 1, 1, 2,   0, 0, 1, 0);
    add(0, 1, 1, 2,   1, 0, 0, 1);
    add(0, 1, 1, 2,   1, 0, 0, 0);
    // 100% duty holds hi
    add(0, 1, 1, 2,   1, 0, 0, 0);
    add(0, 1, 1, 2,   1, 0, 0, 0);
    add(0, 1, 1, 2,   1, 0, 0, 0);
    // rst mid-DEAD returns to OFF, then restart with D=1
    add(0, 1, 0, 4,   0, 0, 1, 0);
    add(1, 1, 0, 4,   0, 0, 0, 0);
    add(0, 1, 0, 1,   0, 0, 1, 0);
    add(0, 1, 0, 1,   0, 1, 0, 0);
    add(0, 1, 0, 1,   0, 1, 0, 0);

    foreach (vecs[i]) begin
      rst      = vecs[i].rst;
      en       = vecs[i].en;
      pwm_in   = vecs[i].pwm;
      dead_cnt = vecs[i].dc;
      @(posedge clk);
      #1;
      chk("hi_out",      i, hi_out,      vecs[i].hi);
      chk("lo_out",      i, lo_out,      vecs[i].lo);
      chk("dead_active", i, dead_active, vecs[i].dead);
      chk("swallow",     i, swallow,     vecs[i].sw);
    end

    // Randomized run driven by an up/down 4-bit PWM model
    cnt = 0; up = 1'b1; run = 0; dmin = 1;
    rst = 1'b0;
    for (int seg = 0; seg < 20; seg++) begin
      en       = 1'b0;
      dead_cnt = 4'($urandom_range(0, 15));
      duty     = $urandom_range(0, 16);
      dmin     = (dead_cnt == '0) ? 1 : int'(dead_cnt);
      for (int c = 0; c < 500; c++) begin
        if (c == 2) en = 1'b1;
        pwm_in = (cnt < duty);
        if (up) begin
          if (cnt == 15) begin up = 1'b0; cnt = 14; end else cnt = cnt + 1;
        end else begin
          if (cnt == 0) begin up = 1'b1; cnt = 1; end else cnt = cnt - 1;
        end
        @(posedge clk);
        #1;
        chk("exclusive", c, hi_out & lo_out, 1'b0);
        if (!hi_out && !lo_out) begin
          run++;
        end else begin
          if (run > 0) begin
            checks++;
            if (run < dmin) begin
              failures++;
              $display("FAIL gap seg=%0d actual=%0d required>=%0d", seg, run, dmin);
            end
          end
          run = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
